// File: rtl/fib_gen.sv
// Fibonacci stream source: emits 0,1,1,2,3,5,... one term per valid/ready transfer,
// stopping after len terms or at the last term that fits in n bits.
module fib_gen #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   len,
  input  logic         out_ready,
  output logic [n-1:0] out,
  output logic         out_valid,
  output logic         last,
  output logic         busy,
  output logic         done
);

  // state   | meaning
  // ST_IDLE | out of reset, waiting for start
  // ST_RUN  | presenting term a on the output stream
  // ST_DONE | sequence finished, waiting for start to restart

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] a_q, a_d;
  logic [n:0]   b_q, b_d;
  logic [7:0]   rem_q, rem_d;

  logic run;
  logic last_w;

  assign run    = (state_q == ST_RUN);
  // b[n] set means the next term overflows n bits, so the current one is final
  assign last_w = run & ((rem_q == 8'd1) | b_q[n]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            a_d     = '0;
            b_d     = (n+1)'(1);
            rem_d   = len;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = ST_DONE;
          end else begin
            a_d   = b_q[n-1:0];
            b_d   = {1'b0, a_q} + b_q;
            rem_d = rem_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
    end
  end

  assign out       = a_q;
  assign out_valid = run;
  assign last      = last_w;
  assign busy      = run;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fib_gen.sv
// Bench for fib_gen: n=4 and n=8 instances against a plain-arithmetic Fibonacci model,
// with table-driven lengths, backpressure, reset, ignored-start and random handshakes.
module tb_fib_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0;
  logic       start8 = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] len = 8'd0;

  logic [3:0] out4;
  logic       v4, l4, b4, d4;
  logic [7:0] out8;
  logic       v8, l8, b8, d8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fib_gen #(.n(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .len(len), .out_ready(out_ready),
    .out(out4), .out_valid(v4), .last(l4), .busy(b4), .done(d4)
  );

  fib_gen #(.n(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .len(len), .out_ready(out_ready),
    .out(out8), .out_valid(v8), .last(l8), .busy(b8), .done(d8)
  );

  typedef struct {
    logic [7:0] len;
    int         cnt4;
    int         fin4;
    int         cnt8;
    int         fin8;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fib(input int k);
    int x = 0, y = 1, t;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // terms emitted: all Fibonacci numbers below 2^nb, capped at ln
  function automatic int fib_count(input int nb, input int ln);
    int c = 0;
    while (c < ln && fib(c) < (1 << nb)) c++;
    return c;
  endfunction

  function automatic bit is_fib(input int v);
    for (int k = 0; k < 64; k++) begin
      if (fib(k) == v) return 1'b1;
      if (fib(k) > v) return 1'b0;
    end
    return 1'b0;
  endfunction

  task automatic smp(input int i, output logic [31:0] o, output logic v, output logic l,
                     output logic b, output logic d);
    if (i == 0) begin
      o = 32'(out4); v = v4; l = l4; b = b4; d = d4;
    end else begin
      o = 32'(out8); v = v8; l = l8; b = b8; d = d8;
    end
  endtask

  // mode: 0 ready=1, 1 random ready, 2 stall 3 cycles at out4==2,
  //       3 start pulse to n=8 at term 21, 4 reset at n=8 term 34
  task automatic run_seq(input logic [7:0] ln, input int mode,
                         input int ec4, input int ef4, input int ec8, input int ef8);
    int c[2], idx[2], post[2], fin[2];
    logic [31:0] so[2];
    logic sv[2], sl[2], sb[2], sd[2];
    logic r;
    int stall = 0;
    bit stalled = 0, pulsed = 0, finished = 0;
    c[0] = fib_count(4, int'(ln));
    c[1] = fib_count(8, int'(ln));
    for (int i = 0; i < 2; i++) begin idx[i] = 0; post[i] = 0; fin[i] = -1; end

    @(negedge clk);
    start4 = 1'b1; start8 = 1'b1; len = ln; out_ready = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0; len = 8'($urandom);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 2; i++) smp(i, so[i], sv[i], sl[i], sb[i], sd[i]);

      if (mode == 4 && sv[1] && so[1] == 32'd34) begin
        rst_n = 1'b0;
        #1;
        check("rst_out8", 32'(out8), 0);
        check("rst_valid8", 32'(v8), 0);
        check("rst_last8", 32'(l8), 0);
        check("rst_busy8", 32'(b8), 0);
        check("rst_done8", 32'(d8), 0);
        check("rst_out4", 32'(out4), 0);
        check("rst_done4", 32'(d4), 0);
        @(negedge clk);
        check("rst_hold8", 32'(v8), 0);
        rst_n = 1'b1;
        return;
      end

      start8 = 1'b0;
      if (mode == 3 && !pulsed && sv[1] && so[1] == 32'd21) begin
        pulsed = 1; start8 = 1'b1; len = 8'd2;
      end

      r = 1'b1;
      if (mode == 1) r = ($urandom_range(0, 9) < 7);
      if (mode == 2) begin
        if (stall > 0) begin
          r = 1'b0; stall--;
        end else if (!stalled && sv[0] && so[0] == 32'd2) begin
          stalled = 1; r = 1'b0; stall = 2;
        end
        if (!r) begin
          check("bp_hold", so[0], 2);
          check("bp_last", 32'(sl[0]), 0);
        end
      end
      out_ready = r;

      for (int i = 0; i < 2; i++) begin
        if (idx[i] < c[i]) begin
          check(i == 0 ? "valid4" : "valid8", 32'(sv[i]), 1);
          check(i == 0 ? "term4" : "term8", so[i], 32'(fib(idx[i])));
          check(i == 0 ? "last4" : "last8", 32'(sl[i]), 32'(idx[i] == c[i] - 1));
          check(i == 0 ? "busy4" : "busy8", 32'(sb[i]), 1);
          if (sv[i] && r) begin
            if (i == 0) check("detector", 32'(is_fib(int'(so[0]))), 1);
            if (sl[i]) fin[i] = int'(so[i]);
            idx[i]++;
          end
        end else begin
          check(i == 0 ? "end_valid4" : "end_valid8", 32'(sv[i]), 0);
          check(i == 0 ? "end_last4" : "end_last8", 32'(sl[i]), 0);
          check(i == 0 ? "end_busy4" : "end_busy8", 32'(sb[i]), 0);
          check(i == 0 ? "end_done4" : "end_done8", 32'(sd[i]), 1);
          post[i]++;
        end
      end
      if (post[0] >= 2 && post[1] >= 2) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    start8 = 1'b0;
    check("seq_timeout", 32'(finished), 1);
    if (ec4 >= 0) check("tbl_cnt4", 32'(idx[0]), 32'(ec4));
    if (ef4 >= 0) check("tbl_fin4", 32'(fin[0]), 32'(ef4));
    if (ec8 >= 0) check("tbl_cnt8", 32'(idx[1]), 32'(ec8));
    if (ef8 >= 0) check("tbl_fin8", 32'(fin[1]), 32'(ef8));
  endtask

  initial begin
    tbl[0] = '{8'd255, 8, 13, 14, 233};
    tbl[1] = '{8'd5,   5, 3,  5,  3};
    tbl[2] = '{8'd1,   1, 0,  1,  0};
    tbl[3] = '{8'd8,   8, 13, 8,  13};
    tbl[4] = '{8'd9,   8, 13, 9,  21};
    tbl[5] = '{8'd14,  8, 13, 14, 233};
    tbl[6] = '{8'd2,   2, 1,  2,  1};

    #2;
    check("reset_out4", 32'(out4), 0);
    check("reset_valid4", 32'(v4), 0);
    check("reset_last4", 32'(l4), 0);
    check("reset_busy4", 32'(b4), 0);
    check("reset_done4", 32'(d4), 0);
    check("reset_out8", 32'(out8), 0);
    check("reset_valid8", 32'(v8), 0);
    check("reset_done8", 32'(d8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid4", 32'(v4), 0);
    check("idle_done4", 32'(d4), 0);

    foreach (tbl[i]) run_seq(tbl[i].len, 0, tbl[i].cnt4, tbl[i].fin4, tbl[i].cnt8, tbl[i].fin8);

    run_seq(8'd255, 2, 8, 13, 14, 233);

    run_seq(8'd0, 0, 0, -1, 0, -1);
    run_seq(8'd3, 0, 3, 1, 3, 1);

    run_seq(8'd255, 3, 8, 13, 14, 233);

    run_seq(8'd255, 4, -1, -1, -1, -1);
    run_seq(8'd255, 0, 8, 13, 14, 233);

    for (int k = 0; k < 10; k++) begin
      logic [7:0] ln;
      ln = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
      run_seq(ln, 1, -1, -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_gen.md
# fib_gen

Sequential Fibonacci sequence generator: on a start pulse it emits the Fibonacci terms 0, 1, 1, 2, 3, 5, … one per accepted handshake on a valid/ready output stream. It stops after a programmable number of terms, or at the last term that fits in `n` bits, whichever comes first. It is the source-side counterpart of the Fibonacci number detectors: its stream feeds a detector, and every term it emits must be classified as Fibonacci.

## Interface
- `n`, default 4: term width in bits; n ≥ 2.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a new sequence; sampled only in IDLE or DONE.
- `len`  input  8  maximum number of terms; sampled with `start`.
- `out_ready`  input  1  downstream accepts `out` this cycle.
- `out`  output  n  current term.
- `out_valid`  output  1  `out` is valid.
- `last`  output  1  the current term is the final term; qualified by `out_valid`.
- `busy`  output  1  high in RUN.
- `done`  output  1  high in DONE.

## Operation
- State registers:
  - `a[n-1:0]` holds the current term and drives `out`.
  - `b[n:0]` holds the next term in n+1 bits; bit n set means the next term is unrepresentable.
  - `rem[7:0]` holds the number of terms still to emit, including the current one.
- States are IDLE, RUN and DONE.
- IDLE/DONE with `start`=1:
  - If `len`=0: go to DONE and emit no terms.
  - Otherwise: load a=0, b=1, rem=`len`; go to RUN.
- In RUN:
  - `out_valid`=1 and `out`=a.
  - `last` = (rem==1) | b[n].
- Handshake: a term transfers on a cycle with `out_valid` & `out_ready`.
  - On transfer with `last`=0: a ← b[n-1:0], b ← a + b (computed in n+1 bits, no truncation), rem ← rem−1.
  - On transfer with `last`=1: go to DONE.
- Sum width: a + b ≤ 2·(2^n−1), so the sum always fits in n+1 bits. b is never advanced once b[n]=1, because `last` is already high at that point.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out`, `last` and every register hold.
- `start` in RUN is ignored. `len` changes outside the start cycle are ignored.
- DONE holds `done`=1 until `start`; `start` in DONE restarts exactly as from IDLE.
- Natural sequence end with `len`=255:
  - n=4 ends at 13 (8 terms).
  - n=8 ends at 233 (14 terms).

## Timing
- Reset, asynchronous on `rst_n`=0:
  - state is IDLE.
  - a=0, b=0, rem=0.
  - `out`=0, `out_valid`=0, `last`=0, `busy`=0, `done`=0.
- Reset mid-RUN aborts the sequence immediately. Outputs take their reset values without waiting for a clock edge.
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Start latency: with `start` sampled at edge T, `out_valid`=1 and `out`=0 from T+1.
- With `len`=0, `done`=1 from T+1 and `out_valid` stays 0.
- Throughput: one term per cycle while `out_ready` is held at 1.
- End of sequence: if the final transfer occurs at edge E, then from E+1 `out_valid`=0, `last`=0, `busy`=0 and `done`=1.
- `start` coinciding with a final transfer is ignored, because the block is still in RUN at that edge. The restart is accepted one cycle later, from DONE.

## Test plan
- Free run, n=4, `len`=255, `out_ready`=1:
  - Terms 0,1,1,2,3,5,8,13 on 8 consecutive cycles.
  - `last` only on 13; `done` rises the cycle after.
- Length limit, n=4, `len`=5: terms 0,1,1,2,3, with `last` on 3 and `done` the next cycle.
- Backpressure, n=4, `len`=255:
  - Drop `out_ready` for 3 cycles while `out`=2.
  - `out` stays 2 and `last` stays 0 throughout; the sequence resumes with 3, and no term is skipped or repeated.
- `len`=0: `start` → `done`=1 next cycle and `out_valid` never asserts. A second `start` with `len`=3 then yields 0,1,1.
- Reset and ignored start, n=8:
  - A `start` pulse while `out`=21 has no effect.
  - Asserting `rst_n`=0 while `out`=34 drops every output to 0 immediately.
  - After release, a new `start` with `len`=255 begins at 0 and ends at 233 after 14 terms.
- Loopback: feed `out` (n=4) into the Fibonacci number detector. The detector output must be 1 for every transferred term.
